port_frame_tx: RTL and testbench
================================

# port_frame_tx

Frame transmitter for the port framing interface (8-bit data with sof/eof and src_rdy/dst_rdy handshakes). It turns a frame request (destination byte + payload length) plus a raw payload byte stream into one framed packet: destination byte, length byte, then the payload bytes. It drives the `in_*` side of a `port_register` or any other port-interface sink, at full throughput of one byte per cycle.

## Interface
- `DATA_WIDTH`, 8, width of payload and output data.
- `LEN_WIDTH`, 8, width of the length field; must be ≤ `DATA_WIDTH`.
- `clk` in 1, single clock; all logic on its rising edge.
- `rst_n` in 1, reset, asynchronous, active-low.
- `start` in 1, frame request; sampled only in IDLE.
- `dest` in DATA_WIDTH, destination byte; latched on accepted `start`.
- `len` in LEN_WIDTH, payload byte count (0 legal); latched on accepted `start`.
- `pl_data` in DATA_WIDTH, payload byte.
- `pl_valid` in 1, `pl_data` valid.
- `pl_ready` out 1, payload byte accepted when `pl_valid && pl_ready`; combinational.
- `out_data` out DATA_WIDTH, frame byte; registered.
- `out_sof` out 1, first byte of frame; registered.
- `out_eof` out 1, last byte of frame; registered.
- `out_src_rdy` out 1, `out_*` valid, active-high; registered.
- `out_dst_rdy` in 1, sink ready, active-high.
- `busy` out 1, high whenever state ≠ IDLE.
- `done` out 1, one-cycle pulse after the eof byte transfers; registered.

## Operation
- Transfer on the output port occurs on a cycle with `out_src_rdy && out_dst_rdy`.
- `adv = !out_src_rdy || out_dst_rdy`: the output slot can be loaded this cycle.
- `out_*` hold their value while `out_src_rdy && !out_dst_rdy`.
- States and transitions:
  - IDLE: if `start`, latch `len` into the counter `cnt`, load `out_data=dest`, `sof=1`, `eof=0`, `src_rdy=1`, then go to HDR. Otherwise stay.
  - HDR: if `adv`, load `out_data` with `len` zero-extended, `sof=0`, `eof=(len==0)`, `src_rdy=1`. Go to DRAIN if `len==0`, else go to PAY.
  - PAY: `pl_ready=adv`. If `pl_valid && pl_ready`, load `pl_data`, `eof=(cnt==1)`, `src_rdy=1`, and decrement `cnt`. If `cnt==1`, go to DRAIN. If `adv && !pl_valid`, set `src_rdy<=0` (bubble).
  - DRAIN: if `out_dst_rdy`, clear `src_rdy` and `eof`, pulse `done`, and go to IDLE.
- `pl_ready` is 0 outside PAY.
- `start` outside IDLE is ignored, and `dest`/`len` changes after acceptance have no effect.
- `cnt` is LEN_WIDTH bits. Maximum frame length is 2^LEN_WIDTH−1 payload bytes + 2 header bytes.

## Timing
- Reset (async assert, sync release) sets:
  - state = IDLE, `cnt=0`;
  - `out_data=0`, `out_sof=0`, `out_eof=0`, `out_src_rdy=0`, `done=0`, `busy=0`;
  - `pl_ready=0`.
- Reset mid-frame: the frame is abandoned with no eof emitted. The next frame after reset release is clean.
- Latency from `start` to output: `start` high at edge k gives `out_src_rdy=1` with `dest` and sof after edge k.
- With `out_dst_rdy=1` and `pl_valid=1` continuously, a frame of N payload bytes occupies N+2 consecutive cycles.
- `done` is high for exactly the cycle after the eof transfer edge, and state = IDLE in that cycle. A new `start` is accepted in that cycle.
- Minimum spacing from one sof to the next is N+3 cycles.
- Payload bubbles produce `out_src_rdy=0` cycles inside a frame. sof and eof appear once per frame, each on exactly one transferred byte.

## Test plan
- Basic frame: `dest=0x05`, `len=3`, payload 01,02,03 with `pl_valid=1`, `out_dst_rdy=1`.
  - Required: transfers on 5 consecutive cycles of 05(sof), 03, 01, 02, 03(eof).
  - `done` pulses once, one cycle after the eof transfer.
  - `busy` is high for 5 cycles.
- Zero length: `dest=0xA0`, `len=0`.
  - Required: A0(sof), 00(eof), then `done`.
  - `pl_ready` never asserts.
- Backpressure: `len=4`, `out_dst_rdy` toggling 1/0 each cycle.
  - Required: `out_*` stable while stalled.
  - Exactly 6 transfers in order, with no duplicate or dropped byte.
  - `pl_ready=0` on every stalled cycle.
- Payload gaps: `len=3`, with `pl_valid` low for 2 cycles between bytes.
  - Required: `out_src_rdy=0` during the gaps.
  - Byte sequence intact, with sof and eof each seen once.
- Ignored start / reset: pulse `start` with `dest=0xFF` during a frame.
  - Required: it has no effect; the current frame completes unchanged and no second frame follows.
  - Then assert `rst_n=0` in PAY: all outputs go to 0 immediately.
  - After release, a new frame with `dest=0x11`, `len=1`, payload 0x22 emits 11(sof), 01, 22(eof).

Source files
------------

// File: rtl/port_frame_tx.sv
// Frame transmitter: emits dest, length, then payload bytes as one sof/eof-delimited frame.
// Latency: start -> sof byte on output after one edge. Backpressure: out_* hold while !out_dst_rdy; pl_ready follows the free output slot.
module port_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_dest,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [DATA_WIDTH-1:0] i_pl_data,
    input  logic                  i_pl_valid,
    output logic                  o_pl_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_sof,
    output logic                  o_out_eof,
    output logic                  o_out_src_rdy,
    input  logic                  i_out_dst_rdy,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_PAY   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_sof;
    logic                    r_eof;
    logic                    r_src_rdy;
    logic                    r_done;

    logic                    w_adv;
    logic [DATA_WIDTH-1:0]   w_len_ext;

    // Output slot is free when empty or being drained by the sink this cycle.
    assign w_adv     = !r_src_rdy || i_out_dst_rdy;
    assign w_len_ext = DATA_WIDTH'(r_cnt);

    assign o_pl_ready    = (r_state == S_PAY) && w_adv;
    assign o_out_data    = r_data;
    assign o_out_sof     = r_sof;
    assign o_out_eof     = r_eof;
    assign o_out_src_rdy = r_src_rdy;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_src_rdy <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt     <= i_len;
                        r_data    <= i_dest;
                        r_sof     <= 1'b1;
                        r_eof     <= 1'b0;
                        r_src_rdy <= 1'b1;
                        r_state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_adv) begin
                        r_data    <= w_len_ext;
                        r_sof     <= 1'b0;
                        r_eof     <= (r_cnt == '0);
                        r_src_rdy <= 1'b1;
                        r_state   <= (r_cnt == '0) ? S_DRAIN : S_PAY;
                    end
                end
                S_PAY: begin
                    if (i_pl_valid && w_adv) begin
                        r_data    <= i_pl_data;
                        r_sof     <= 1'b0;
                        r_eof     <= (r_cnt == LEN_WIDTH'(1));
                        r_src_rdy <= 1'b1;
                        r_cnt     <= r_cnt - LEN_WIDTH'(1);
                        if (r_cnt == LEN_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_adv) begin
                        // Payload starved: previous byte left, nothing to replace it.
                        r_src_rdy <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (i_out_dst_rdy) begin
                        r_src_rdy <= 1'b0;
                        r_eof     <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_frame_tx.sv
// Bench for port_frame_tx: directed scenarios plus random frames against a byte-sequence model.
module tb_port_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dest;
    logic [7:0] len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       out_src_rdy;
    logic       out_dst_rdy;
    logic       busy;
    logic       done;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] pay_q[$];

    always #5 clk = ~clk;

    port_frame_tx #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_dest        (dest),
        .i_len         (len),
        .i_pl_data     (pl_data),
        .i_pl_valid    (pl_valid),
        .o_pl_ready    (pl_ready),
        .o_out_data    (out_data),
        .o_out_sof     (out_sof),
        .o_out_eof     (out_eof),
        .o_out_src_rdy (out_src_rdy),
        .i_out_dst_rdy (out_dst_rdy),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame = dest, len, payload bytes; bp: 0 always ready, 1 toggling, 2 random.
    task automatic send_frame(input logic [7:0] d, input logic [7:0] l, input int gap,
                              input int bp, input bit inj);
        logic [7:0] exp_b[$];
        logic [7:0] pq[$];
        int   idx, busy_n, hs_n, rdy_n, gap_cnt, eof_cyc, cyc;
        bit   seen_done, prev_stall, stalled;
        logic [7:0] p_data;
        logic p_sof, p_eof, p_src;

        pq = pay_q;
        exp_b = {};
        exp_b.push_back(d);
        exp_b.push_back(l);
        foreach (pq[i]) exp_b.push_back(pq[i]);

        idx = 0; busy_n = 0; hs_n = 0; rdy_n = 0; gap_cnt = 0; eof_cyc = -10;
        seen_done = 0; prev_stall = 0;
        p_data = '0; p_sof = 0; p_eof = 0; p_src = 0;

        @(posedge clk); #1;
        for (cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            start = (cyc == 0) || (inj && cyc == 2);
            dest  = (cyc == 0) ? d : ((inj && cyc == 2) ? 8'hFF : 8'($urandom));
            len   = (cyc == 0) ? l : 8'($urandom);
            if (gap_cnt > 0) begin
                gap_cnt--;
                pl_valid = 1'b0;
                pl_data  = 8'($urandom);
            end else if (cyc > 0 && pq.size() > 0) begin
                pl_valid = 1'b1;
                pl_data  = pq[0];
            end else begin
                pl_valid = 1'b0;
                pl_data  = 8'($urandom);
            end
            case (bp)
                0:       out_dst_rdy = 1'b1;
                1:       out_dst_rdy = (cyc % 2 == 0);
                default: out_dst_rdy = 1'($urandom_range(0, 1));
            endcase

            @(negedge clk);
            stalled = out_src_rdy && !out_dst_rdy;
            if (prev_stall) begin
                chk("hold_data", 32'(out_data), 32'(p_data));
                chk("hold_sof", 32'(out_sof), 32'(p_sof));
                chk("hold_eof", 32'(out_eof), 32'(p_eof));
                chk("hold_src_rdy", 32'(out_src_rdy), 32'(p_src));
            end
            if (stalled) chk("stall_pl_ready", 32'(pl_ready), 32'(0));
            if (pl_ready) rdy_n++;
            if (pl_valid && pl_ready) begin
                hs_n++;
                void'(pq.pop_front());
                gap_cnt = gap;
            end
            if (busy) busy_n++;
            if (out_src_rdy && out_dst_rdy) begin
                if (idx < exp_b.size()) begin
                    chk("xfer_data", 32'(out_data), 32'(exp_b[idx]));
                    chk("xfer_sof", 32'(out_sof), 32'(idx == 0));
                    chk("xfer_eof", 32'(out_eof), 32'(idx == exp_b.size() - 1));
                    if (idx == exp_b.size() - 1) eof_cyc = cyc;
                end else begin
                    chk("extra_xfer", 32'(idx), 32'(exp_b.size() - 1));
                end
                idx++;
            end
            if (done) begin
                seen_done = 1;
                chk("done_after_eof", 32'(cyc), 32'(eof_cyc + 1));
                chk("idle_on_done", 32'(busy), 32'(0));
            end
            prev_stall = stalled;
            p_data = out_data; p_sof = out_sof; p_eof = out_eof; p_src = out_src_rdy;
        end

        chk("done_seen", 32'(seen_done), 32'(1));
        chk("xfer_count", 32'(idx), 32'(exp_b.size()));
        chk("payload_hs", 32'(hs_n), 32'(l));
        if (l == 0) chk("zero_len_pl_ready", 32'(rdy_n), 32'(0));
        if (gap == 0 && bp == 0) chk("busy_cycles", 32'(busy_n), 32'(l) + 32'd2);

        @(posedge clk); #1;
        start = 1'b0; pl_valid = 1'b0; out_dst_rdy = 1'b1;
        for (int k = 0; k < (inj ? 4 : 1); k++) begin
            @(negedge clk);
            chk("post_done_low", 32'(done), 32'(0));
            chk("post_src_rdy", 32'(out_src_rdy), 32'(0));
            chk("post_busy", 32'(busy), 32'(0));
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dest = '0; len = '0;
        pl_data = '0; pl_valid = 1'b0; out_dst_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_sof", 32'(out_sof), 32'(0));
        chk("rst_eof", 32'(out_eof), 32'(0));
        chk("rst_src_rdy", 32'(out_src_rdy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_pl_ready", 32'(pl_ready), 32'(0));

        pay_q = {8'h01, 8'h02, 8'h03};
        send_frame(8'h05, 8'd3, 0, 0, 1'b0);

        pay_q = {};
        send_frame(8'hA0, 8'd0, 0, 0, 1'b0);

        pay_q = {};
        for (int i = 0; i < 4; i++) pay_q.push_back(8'($urandom));
        send_frame(8'h3C, 8'd4, 0, 1, 1'b0);

        pay_q = {8'h9A, 8'hBC, 8'hDE};
        send_frame(8'h47, 8'd3, 2, 0, 1'b0);

        pay_q = {8'h10, 8'h20, 8'h30};
        send_frame(8'h66, 8'd3, 0, 0, 1'b1);

        // Abandon a frame mid-payload with an asynchronous reset.
        @(posedge clk); #1;
        start = 1'b1; dest = 8'h33; len = 8'd5;
        pl_valid = 1'b1; pl_data = 8'h44; out_dst_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        chk("pre_rst_in_pay", 32'(pl_ready), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(out_data), 32'(0));
        chk("mid_rst_sof", 32'(out_sof), 32'(0));
        chk("mid_rst_eof", 32'(out_eof), 32'(0));
        chk("mid_rst_src_rdy", 32'(out_src_rdy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_pl_ready", 32'(pl_ready), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; pl_valid = 1'b0;

        pay_q = {8'h22};
        send_frame(8'h11, 8'd1, 0, 0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            int l;
            l = $urandom_range(0, 20);
            pay_q = {};
            for (int i = 0; i < l; i++) pay_q.push_back(8'($urandom));
            send_frame(8'($urandom), 8'(l), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
